// File: rtl/instr_reg_arbiter.sv
// Write-side arbiter and in-order read sequencer in front of instr_register.
// Define IR_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module instr_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OPC_W   = 4,
    parameter int OP_W    = 32,
    parameter int ADDR_W  = 5,
    parameter int IW_W    = 132
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
    input  logic [NUM_REQ*OP_W-1:0]   req_operand_a,
    input  logic [NUM_REQ*OP_W-1:0]   req_operand_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      load_en,
    output logic [OPC_W-1:0]          opcode,
    output logic [OP_W-1:0]           operand_a,
    output logic [OP_W-1:0]           operand_b,
    output logic [ADDR_W-1:0]         write_pointer,
    output logic [ADDR_W-1:0]         read_pointer,
    input  logic [IW_W-1:0]           instruction_word,
    input  logic                      rd_req,
    output logic                      rd_valid,
    output logic [IW_W-1:0]           rd_data,
    output logic                      full,
    output logic                      empty
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OCC_W = ADDR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [NUM_REQ-1:0][OPC_W-1:0] opc_arr;
    logic [NUM_REQ-1:0][OP_W-1:0]  opa_arr;
    logic [NUM_REQ-1:0][OP_W-1:0]  opb_arr;

    assign opc_arr = req_opcode;
    assign opa_arr = req_operand_a;
    assign opb_arr = req_operand_b;

    logic [NUM_REQ-1:0] gnt_raw;
    logic [RR_W-1:0]    gnt_idx;
    logic               found;
    logic               xfer;
    logic               rd_acc;
    logic               full_w;
    logic               empty_w;

    logic               load_en_q,  load_en_d;
    logic [OPC_W-1:0]   opcode_q,   opcode_d;
    logic [OP_W-1:0]    opa_q,      opa_d;
    logic [OP_W-1:0]    opb_q,      opb_d;
    logic [ADDR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0]   occ_q,      occ_d;
    logic               rd_valid_q, rd_valid_d;
    logic [IW_W-1:0]    rd_data_q,  rd_data_d;

`ifdef IR_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_raw = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                gnt_raw[i] = 1'b1;
                gnt_idx    = RR_W'(i);
                found      = 1'b1;
            end
        end
    end
`else
    localparam logic [RR_W:0] NREQ = (RR_W+1)'(NUM_REQ);

    logic [RR_W-1:0] rr_q, rr_d;
    logic [RR_W:0]   cand;

    // Scan requesters starting at the RR pointer, wrapping at NUM_REQ.
    always_comb begin
        gnt_raw = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (RR_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req_valid[cand[RR_W-1:0]]) begin
                gnt_raw[cand[RR_W-1:0]] = 1'b1;
                gnt_idx                 = cand[RR_W-1:0];
                found                   = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer) rr_d = (gnt_idx == RR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`endif

    // No write bypass when full: a same-cycle read only frees the slot next cycle.
    assign full_w  = (occ_q == DEPTH);
    assign empty_w = ((occ_q - OCC_W'(load_en_q)) == '0);
    assign gnt     = (reset || full_w) ? '0 : gnt_raw;
    assign xfer    = |(req_valid & gnt);
    assign rd_acc  = rd_req & ~empty_w & ~reset;

    always_comb begin
        load_en_d  = xfer;
        opcode_d   = opcode_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        if (xfer) begin
            opcode_d = opc_arr[gnt_idx];
            opa_d    = opa_arr[gnt_idx];
            opb_d    = opb_arr[gnt_idx];
        end
        wr_ptr_d   = wr_ptr_q + ADDR_W'(load_en_q);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(rd_acc);
        occ_d      = occ_q + OCC_W'(xfer) - OCC_W'(rd_acc);
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? instruction_word : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_en_q  <= 1'b0;
            opcode_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            load_en_q  <= load_en_d;
            opcode_q   <= opcode_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // A load still in flight when reset rises must not reach the register file.
    assign load_en       = load_en_q & ~reset;
    assign opcode        = opcode_q;
    assign operand_a     = opa_q;
    assign operand_b     = opb_q;
    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign full          = full_w;
    assign empty         = empty_w;

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// Bench for instr_reg_arbiter: directed scenarios plus random traffic against a
// transaction-count model with a write-order scoreboard.
module tb_instr_reg_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OPC_W   = 4;
    localparam int OP_W    = 32;
    localparam int ADDR_W  = 5;
    localparam int IW_W    = 132;
    localparam int DEPTH   = 32;

    logic clk = 1'b0;
    logic reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0][OPC_W-1:0] r_opc;
    logic [NUM_REQ-1:0][OP_W-1:0]  r_a;
    logic [NUM_REQ-1:0][OP_W-1:0]  r_b;
    logic [NUM_REQ-1:0] gnt;
    logic load_en;
    logic [OPC_W-1:0] opcode;
    logic [OP_W-1:0] operand_a, operand_b;
    logic [ADDR_W-1:0] write_pointer, read_pointer;
    logic [IW_W-1:0] instruction_word, rd_data;
    logic rd_req, rd_valid, full, empty;

    logic [IW_W-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    instr_reg_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_opcode(r_opc),
        .req_operand_a(r_a), .req_operand_b(r_b),
        .gnt(gnt), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .full(full), .empty(empty)
    );

    function automatic logic [IW_W-1:0] pack(input logic [OPC_W-1:0] o,
                                             input logic [OP_W-1:0] a,
                                             input logic [OP_W-1:0] b);
        return {o, a, b, ~a, ~b};
    endfunction

    // Stand-in for instr_register: write on load_en, combinational read.
    always @(posedge clk) if (load_en) mem[write_pointer] <= pack(opcode, operand_a, operand_b);
    assign instruction_word = mem[read_pointer];

    // Reference model: transaction totals, RR index and an in-order scoreboard.
    int m_rr, tot_xfer, tot_load, tot_rd;
    bit m_ld, m_rdv;
    logic [OPC_W-1:0] m_opc;
    logic [OP_W-1:0] m_a, m_b;
    logic [IW_W-1:0] m_rdata;
    logic [IW_W-1:0] sb [$];
    int n_checks = 0, n_errors = 0;

    task automatic model_reset();
        m_rr = 0; tot_xfer = 0; tot_load = 0; tot_rd = 0;
        m_ld = 0; m_rdv = 0; m_opc = '0; m_a = '0; m_b = '0; m_rdata = '0;
        sb.delete();
    endtask

    function automatic logic [NUM_REQ-1:0] exp_gnt();
        logic [NUM_REQ-1:0] g = '0;
        if (reset || (tot_xfer - tot_rd) == DEPTH) return g;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (m_rr + k) % NUM_REQ;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic tick();
        logic [NUM_REQ-1:0] g;
        int idx;
        bit acc;
        g   = exp_gnt();
        acc = rd_req && !reset && (tot_load - tot_rd) != 0;
        idx = -1;
        for (int k = 0; k < NUM_REQ; k++) if (g[k]) idx = k;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (m_ld) tot_load++;
            m_ld = (idx >= 0);
            if (idx >= 0) begin
                m_opc = r_opc[idx]; m_a = r_a[idx]; m_b = r_b[idx];
                sb.push_back(pack(m_opc, m_a, m_b));
                tot_xfer++;
                m_rr = (idx + 1) % NUM_REQ;
            end
            m_rdv = acc;
            if (acc) begin
                m_rdata = sb.pop_front();
                tot_rd++;
            end
        end
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            r_opc[i] = OPC_W'($urandom);
            r_a[i]   = $urandom;
            r_b[i]   = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; rd_req = 1'b1;
        randomize_data();
        #1;
        n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL reset_gnt_first got %b exp 0000", gnt); end
        tick(); tick();
        n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        n_checks++; if (load_en !== 1'b0) begin n_errors++; $display("FAIL reset_load_en got %b exp 0", load_en); end
        n_checks++; if (write_pointer !== '0) begin n_errors++; $display("FAIL reset_wp got %0d exp 0", write_pointer); end
        n_checks++; if (read_pointer !== '0) begin n_errors++; $display("FAIL reset_rp got %0d exp 0", read_pointer); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", full); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        reset = 1'b0; req_valid = '0; rd_req = 1'b0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100; r_opc[2] = 4'd3; r_a[2] = 32'd5; r_b[2] = 32'd7;
        #1;
        n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
        tick(); req_valid = '0; #1;
        n_checks++; if (load_en !== 1'b1) begin n_errors++; $display("FAIL single_load_en got %b exp 1", load_en); end
        n_checks++; if (write_pointer !== '0) begin n_errors++; $display("FAIL single_wp got %0d exp 0", write_pointer); end
        n_checks++; if (opcode !== 4'd3) begin n_errors++; $display("FAIL single_opcode got %0d exp 3", opcode); end
        n_checks++; if (operand_a !== 32'd5 || operand_b !== 32'd7) begin n_errors++; $display("FAIL single_operands got %0d/%0d exp 5/7", operand_a, operand_b); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL single_empty_t1 got %b exp 1", empty); end
        tick(); rd_req = 1'b1; #1;
        n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL single_empty_t2 got %b exp 0", empty); end
        tick(); rd_req = 1'b0; #1;
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
        n_checks++; if (rd_data !== pack(4'd3, 32'd5, 32'd7)) begin n_errors++; $display("FAIL single_rd_data got %h exp %h", rd_data, pack(4'd3, 32'd5, 32'd7)); end
        n_checks++; if (read_pointer !== 5'd1) begin n_errors++; $display("FAIL single_rp got %0d exp 1", read_pointer); end
        tick(); #1;
        n_checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_errors++; $display("FAIL single_drained rd_valid=%b empty=%b exp 0/1", rd_valid, empty); end
    endtask

    task automatic test_rr();
        do_reset(1);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            #1;
            n_checks++; if (gnt !== 4'(1 << (k % 4))) begin n_errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, 4'(1 << (k % 4))); end
            if (k > 0) begin
                n_checks++; if (load_en !== 1'b1 || write_pointer !== ADDR_W'(k - 1)) begin n_errors++; $display("FAIL rr_wp[%0d] got %b/%0d exp 1/%0d", k, load_en, write_pointer, k - 1); end
            end
            tick();
        end
        req_valid = '0; #1;
        n_checks++; if (load_en !== 1'b1 || write_pointer !== 5'd7) begin n_errors++; $display("FAIL rr_wp_last got %b/%0d exp 1/7", load_en, write_pointer); end
        n_checks++; if (opcode !== m_opc || operand_a !== m_a) begin n_errors++; $display("FAIL rr_data got %h/%h exp %h/%h", opcode, operand_a, m_opc, m_a); end
        tick();
    endtask

    task automatic test_full();
        int cyc = 0;
        do_reset(1);
        while (tot_xfer < DEPTH && cyc < 100) begin
            randomize_data();
            req_valid = 4'($urandom_range(1, 15));
            #1;
            n_checks++; if (gnt !== exp_gnt()) begin n_errors++; $display("FAIL full_fill_gnt got %b exp %b", gnt, exp_gnt()); end
            tick();
            cyc++;
        end
        n_checks++; if (tot_xfer != DEPTH) begin n_errors++; $display("FAIL full_fill_timeout got %0d transfers exp %0d", tot_xfer, DEPTH); end
        req_valid = '1; rd_req = 1'b1; #1;
        n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL full_flag got %b exp 1", full); end
        n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL full_gnt_nobypass got %b exp 0000", gnt); end
        n_checks++; if (load_en !== 1'b1 || write_pointer !== 5'd31) begin n_errors++; $display("FAIL full_last_wp got %b/%0d exp 1/31", load_en, write_pointer); end
        tick(); rd_req = 1'b0; #1;
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL full_after_read got %b exp 0", full); end
        n_checks++; if (gnt === '0 || gnt !== exp_gnt()) begin n_errors++; $display("FAIL full_regrant got %b exp %b", gnt, exp_gnt()); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_rdata) begin n_errors++; $display("FAIL full_rd_data got %b/%h exp 1/%h", rd_valid, rd_data, m_rdata); end
        tick(); req_valid = '0; #1;
        n_checks++; if (load_en !== 1'b1 || write_pointer !== '0) begin n_errors++; $display("FAIL full_wrap_wp got %b/%0d exp 1/0", load_en, write_pointer); end
        n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL full_refull got %b exp 1", full); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            randomize_data();
            req_valid = 4'($urandom_range(1, 15)); rd_req = 1'b0; #1;
            n_checks++; if (gnt !== exp_gnt()) begin n_errors++; $display("FAIL wrap_gnt[%0d] got %b exp %b", i, gnt, exp_gnt()); end
            tick(); req_valid = '0; #1;
            n_checks++; if (load_en !== 1'b1 || write_pointer !== ADDR_W'(i % DEPTH)) begin n_errors++; $display("FAIL wrap_wp[%0d] got %b/%0d exp 1/%0d", i, load_en, write_pointer, i % DEPTH); end
            tick(); rd_req = 1'b1; #1;
            n_checks++; if (empty !== 1'b0 || read_pointer !== ADDR_W'(i % DEPTH)) begin n_errors++; $display("FAIL wrap_rp[%0d] got %b/%0d exp 0/%0d", i, empty, read_pointer, i % DEPTH); end
            tick(); rd_req = 1'b0; #1;
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_rdata) begin n_errors++; $display("FAIL wrap_rd_data[%0d] got %b/%h exp 1/%h", i, rd_valid, rd_data, m_rdata); end
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        randomize_data();
        req_valid = 4'b0010; #1;
        n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL midrst_gnt got %b exp 0010", gnt); end
        tick(); reset = 1'b1; req_valid = '1; #1;
        n_checks++; if (load_en !== 1'b0) begin n_errors++; $display("FAIL midrst_load_dropped got %b exp 0", load_en); end
        n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL midrst_gnt_forced got %b exp 0000", gnt); end
        tick(); #1;
        n_checks++; if (load_en !== 1'b0 || write_pointer !== '0 || read_pointer !== '0) begin n_errors++; $display("FAIL midrst_state got %b/%0d/%0d exp 0/0/0", load_en, write_pointer, read_pointer); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL midrst_flags got %b/%b exp 1/0", empty, full); end
        reset = 1'b0; req_valid = 4'b0110; #1;
        n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL midrst_rr_restart got %b exp 0010", gnt); end
        tick(); req_valid = '0; #1;
        n_checks++; if (load_en !== 1'b1 || write_pointer !== '0) begin n_errors++; $display("FAIL midrst_new_wp got %b/%0d exp 1/0", load_en, write_pointer); end
        tick();
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 600; c++) begin
            randomize_data();
            req_valid = ($urandom_range(0, 9) < 7) ? 4'($urandom) : '0;
            rd_req    = ($urandom_range(0, 9) < 4);
            reset     = ($urandom_range(0, 99) == 0);
            #1;
            n_checks++; if (gnt !== exp_gnt()) begin n_errors++; $display("FAIL rand_gnt[%0d] got %b exp %b", c, gnt, exp_gnt()); end
            n_checks++; if (load_en !== (m_ld & ~reset)) begin n_errors++; $display("FAIL rand_load_en[%0d] got %b exp %b", c, load_en, m_ld & ~reset); end
            n_checks++; if (write_pointer !== ADDR_W'(tot_load) || read_pointer !== ADDR_W'(tot_rd)) begin n_errors++; $display("FAIL rand_ptrs[%0d] got %0d/%0d exp %0d/%0d", c, write_pointer, read_pointer, tot_load % DEPTH, tot_rd % DEPTH); end
            n_checks++; if (full !== ((tot_xfer - tot_rd) == DEPTH) || empty !== ((tot_load - tot_rd) == 0)) begin n_errors++; $display("FAIL rand_flags[%0d] got %b/%b occ=%0d ready=%0d", c, full, empty, tot_xfer - tot_rd, tot_load - tot_rd); end
            n_checks++; if (opcode !== m_opc || operand_a !== m_a || operand_b !== m_b) begin n_errors++; $display("FAIL rand_load_data[%0d] got %h/%h/%h exp %h/%h/%h", c, opcode, operand_a, operand_b, m_opc, m_a, m_b); end
            n_checks++; if (rd_valid !== m_rdv || rd_data !== m_rdata) begin n_errors++; $display("FAIL rand_rd[%0d] got %b/%h exp %b/%h", c, rd_valid, rd_data, m_rdv, m_rdata); end
            tick();
        end
        reset = 1'b0; req_valid = '0; rd_req = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; req_valid = '0; rd_req = 1'b0;
        r_opc = '0; r_a = '0; r_b = '0;
        test_reset();
        test_single();
        test_rr();
        test_full();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
